// File: rtl/rad_cdc_mcp_pkg.sv
// Shared types and width helpers for the multi-entry MCP CDC send side.
package rad_cdc_mcp_pkg;

  // Coarse link state, decoded from the credit count and the error flags.
  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FULL,
    ERROR
  } state_e;

  // Slot index width; a single-slot link still carries a 1-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Outstanding-count width: must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Watchdog counter width: must represent 0..limit inclusive.
  function automatic int timer_width(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/rad_cdc_mcp_ack_timer.sv
// Saturating ack watchdog: counts cycles while run_i is high and reports expiry.
module rad_cdc_mcp_ack_timer
  import rad_cdc_mcp_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic aclk,
  input  logic arst_n,
  input  logic run_i,
  input  logic clear_i,
  output logic expired_o
);

  generate
    if (TIMEOUT == 0) begin : g_off
      // Watchdog disabled: nothing to count, never expires.
      logic unused_inputs;
      assign unused_inputs = ^{aclk, arst_n, run_i, clear_i};
      assign expired_o     = 1'b0;
    end else begin : g_on
      localparam int TW = timer_width(TIMEOUT);
      localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);
      localparam logic [TW-1:0] ONE   = TW'(1);

      logic [TW-1:0] timer_q;
      logic [TW-1:0] timer_d;

      // Next timer value: clear wins, otherwise count up and hold at the limit.
      always_comb begin
        timer_d = timer_q;
        if (clear_i) begin
          timer_d = '0;
        end else if (run_i && (timer_q != LIMIT)) begin
          timer_d = timer_q + ONE;
        end
      end

      // Timer register with asynchronous reset.
      always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
          timer_q <= '0;
        end else begin
          timer_q <= timer_d;
        end
      end

      assign expired_o = (timer_q == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/rad_cdc_mcp_asend_credit.sv
// Source-side credit controller for a multi-entry MCP CDC link: issues slot
// pointers, tracks words in flight, and flags ack timeouts and spurious acks.
module rad_cdc_mcp_asend_credit
  import rad_cdc_mcp_pkg::*;
#(
  parameter  int DEPTH   = 2,
  parameter  int TIMEOUT = 256,
  localparam int PTR_W   = ptr_width(DEPTH),
  localparam int CNT_W   = cnt_width(DEPTH)
) (
  input  logic             aclk,
  input  logic             arst_n,
  input  logic             asend,
  output logic             aready,
  output logic [PTR_W-1:0] aptr,
  input  logic             aack,
  output logic [CNT_W-1:0] aoutstanding,
  output logic             atimeout,
  output logic             aspurious,
  input  logic             aclr_err
);

  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("rad_cdc_mcp_asend_credit: DEPTH must be at least 1");
    end
    if (TIMEOUT < 0) begin : g_bad_timeout
      $error("rad_cdc_mcp_asend_credit: TIMEOUT must not be negative");
    end
  endgenerate

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             spurious_q, spurious_d;
  logic             timeout_q, timeout_d;
  logic             expired;
  logic             accept;
  logic             ack_valid;
  logic             ack_spur;
  state_e           state;

  // An ack never refers to a send in the same cycle, so validity uses the
  // registered count only.
  assign ack_valid = aack && (cnt_q != '0);
  assign ack_spur  = aack && (cnt_q == '0);

  // Timeout is visible as soon as the timer hits its limit, then held sticky.
  assign atimeout  = timeout_q | expired;
  assign aspurious = spurious_q;
  assign aready    = (cnt_q < DEPTH_C) && !atimeout && !spurious_q;
  assign accept    = asend && aready && !aclr_err;

  assign aptr         = ptr_q;
  assign aoutstanding = cnt_q;

  rad_cdc_mcp_ack_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_ack_timer (
    .aclk     (aclk),
    .arst_n   (arst_n),
    .run_i    (cnt_q != '0),
    .clear_i  (aclr_err || (cnt_q == '0) || ack_valid),
    .expired_o(expired)
  );

  // Next-state: flush dominates; otherwise credit count, pointer and sticky flags.
  always_comb begin
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    spurious_d = spurious_q | ack_spur;
    timeout_d  = timeout_q | expired;
    if (aclr_err) begin
      cnt_d      = '0;
      ptr_d      = '0;
      spurious_d = 1'b0;
      timeout_d  = 1'b0;
    end else begin
      if (accept && !ack_valid) begin
        cnt_d = cnt_q + CNT_ONE;
      end else if (!accept && ack_valid) begin
        cnt_d = cnt_q - CNT_ONE;
      end
      if (accept) begin
        ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_ONE;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q      <= '0;
      ptr_q      <= '0;
      spurious_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      spurious_q <= spurious_d;
      timeout_q  <= timeout_d;
    end
  end

  // Debug decode of the link state.
  always_comb begin
    state = ACTIVE;
    if (atimeout || spurious_q) begin
      state = ERROR;
    end else if (cnt_q == '0) begin
      state = IDLE;
    end else if (cnt_q == DEPTH_C) begin
      state = FULL;
    end
  end

  a_cnt_bound : assert property (@(posedge aclk) disable iff (!arst_n)
    cnt_q <= DEPTH_C);
  a_no_accept_blocked : assert property (@(posedge aclk) disable iff (!arst_n)
    !aready |-> !accept);
  a_full_blocks : assert property (@(posedge aclk) disable iff (!arst_n)
    (state == FULL) |-> !aready);

endmodule
